// File: rtl/uart_defs.sv
// Shared UART definitions: state encodings and default bit timing.
// Also the intended header for the future uart_tx.
package uart_defs;

    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input.
// RESET_VAL selects the value both flops take during reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling. Emits each good byte with a
// one-cycle rxfinish strobe; false starts are dropped and bad stop bits flagged.
module uart_rx
    import uart_defs::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rxdata,
    output logic       rxfinish,
    output logic       rxerror
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_e      state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       idx_r, idx_s;
    logic [7:0]       shift_r, shift_s;
    logic [7:0]       data_r, data_s;
    logic             finish_r, finish_s;
    logic             error_r, error_s;
    logic             rx_s;
    logic             tick_s;

    sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // Next-state and datapath decisions; the counter hits zero on each sample point.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        idx_s    = idx_r;
        shift_s  = shift_r;
        data_s   = data_r;
        finish_s = 1'b0;
        error_s  = 1'b0;
        tick_s   = (cnt_r == {CNT_W{1'b0}});

        case (state_r)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_s = ST_START;
                    cnt_s   = HALF_RELOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    if (rx_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DATA;
                        idx_s   = 3'd0;
                        cnt_s   = BIT_RELOAD;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    shift_s = {rx_s, shift_r[7:1]};
                    cnt_s   = BIT_RELOAD;
                    if (idx_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        idx_s = idx_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_STOP: begin
                // Back to IDLE at mid-stop so a frame may follow with no gap.
                if (tick_s) begin
                    if (rx_s) begin
                        data_s   = shift_r;
                        finish_s = 1'b1;
                        state_s  = ST_IDLE;
                    end else begin
                        error_s = 1'b1;
                        state_s = ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            idx_r    <= 3'd0;
            shift_r  <= 8'h00;
            data_r   <= 8'h00;
            finish_r <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            idx_r    <= idx_s;
            shift_r  <= shift_s;
            data_r   <= data_s;
            finish_r <= finish_s;
            error_r  <= error_s;
        end
    end

    assign rxdata   = data_r;
    assign rxfinish = finish_r;
    assign rxerror  = error_r;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a sender task pushes the expected outcome,
// derived from where the receiver's sample points fall on the sent waveform.
module tb_uart_rx;

    localparam int C   = 16;
    localparam int LAT = 2 + C / 2 + 9 * C + 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] rxdata;
    logic       rxfinish;
    logic       rxerror;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rxdata   (rxdata),
        .rxfinish (rxfinish),
        .rxerror  (rxerror)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] last_good = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Line level at offset s cycles after the start edge of a frame sent with period per.
    function automatic logic line_at(input logic [7:0] b, input logic stop, input int per,
                                     input logic after, input int s);
        int j;
        j = s / per;
        if (j == 0)      return 1'b0;
        else if (j <= 8) return b[j-1];
        else if (j == 9) return stop;
        else             return after;
    endfunction

    // Sends one frame; the expected outcome is what the ideal sample points see.
    task automatic send(input logic [7:0] b, input logic stop, input int per, input logic after);
        exp_t       e;
        logic [7:0] got;
        if (line_at(b, stop, per, after, C / 2) == 1'b0) begin
            for (int i = 0; i < 8; i++) got[i] = line_at(b, stop, per, after, C / 2 + (i + 1) * C);
            e.at = cyc + LAT;
            if (line_at(b, stop, per, after, C / 2 + 9 * C)) begin
                e.is_err = 1'b0;
                e.data   = got;
            end else begin
                e.is_err = 1'b1;
                e.data   = 8'h00;
            end
            sb.push_back(e);
        end
        rx = 1'b0;
        tick(per);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(per);
        end
        rx = stop;
        tick(per);
        rx = after;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            tick(1);
            n++;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_good = 8'h00;
            end else if (rxfinish || rxerror) begin
                check("pulse_exclusive", 32'(rxfinish & rxerror), 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: finish=%0b error=%0b data=%0h, none expected (cycle %0d)",
                             rxfinish, rxerror, rxdata, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("pulse_is_error", 32'(rxerror), 32'(mon_e.is_err));
                    check("pulse_cycle", cyc, mon_e.at);
                    if (!mon_e.is_err) begin
                        check("rxdata", rxdata, mon_e.data);
                        last_good = mon_e.data;
                    end else begin
                        check("rxdata_held_on_error", rxdata, last_good);
                    end
                end
            end else begin
                check("rxdata_stable", rxdata, last_good);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [7:0] c3;
        c3 = 8'hC3;

        tick(5);
        check("reset_rxdata", rxdata, 8'h00);
        check("reset_rxfinish", 32'(rxfinish), 32'd0);
        check("reset_rxerror", 32'(rxerror), 32'd0);
        rst_n = 1'b1;
        tick(5);

        // Single frame
        send(8'hA5, 1'b1, C, 1'b1);
        drain(200);
        tick(10);

        // Back-to-back, no idle time
        send(8'h00, 1'b1, C, 1'b1);
        send(8'hFF, 1'b1, C, 1'b1);
        send(8'h3C, 1'b1, C, 1'b1);
        drain(300);
        tick(10);

        // False start glitch then a good frame
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(40);
        send(8'h5A, 1'b1, C, 1'b1);
        drain(200);
        tick(10);

        // Framing error, line held low, then recovery
        send(8'h81, 1'b0, C, 1'b0);
        tick(40);
        rx = 1'b1;
        tick(5);
        send(8'h42, 1'b1, C, 1'b1);
        drain(200);
        tick(10);

        // Reset during data bit 4 of 8'hC3
        rx = 1'b0;
        tick(C);
        for (int i = 0; i < 4; i++) begin
            rx = c3[i];
            tick(C);
        end
        rx = c3[4];
        tick(C / 2);
        rst_n = 1'b0;
        #1;
        check("midreset_rxdata", rxdata, 8'h00);
        check("midreset_rxfinish", 32'(rxfinish), 32'd0);
        check("midreset_rxerror", 32'(rxerror), 32'd0);
        rx = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(20);
        send(8'h17, 1'b1, C, 1'b1);
        drain(200);
        tick(10);

        // Baud skew: sender period 15 and 17
        send(8'h96, 1'b1, 15, 1'b1);
        tick(20);
        drain(200);
        send(8'h96, 1'b1, 17, 1'b1);
        tick(20);
        drain(200);
        tick(10);

        // Random bytes, random gaps, occasional bad stop bit
        repeat (14) begin
            b = 8'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                send(b, 1'b0, C, 1'b0);
                tick(C);
                rx = 1'b1;
                tick(4 + $urandom_range(0, 10));
            end else begin
                send(b, 1'b1, C, 1'b1);
                tick($urandom_range(0, 20));
            end
        end
        drain(400);
        tick(50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
